// File: rtl/move_cmd_exec.sv
// Command executor: accepts cal/move commands from the tour mux, turns to the
// desired heading, ramps forward speed over N squares and reports completion.
module move_cmd_exec #(
    parameter logic [9:0]  FAST_INC  = 10'd24,
    parameter logic [9:0]  SLOW_DEC  = 10'd48,
    parameter logic [9:0]  MAX_FRWRD = 10'h2A0,
    parameter logic [11:0] ERR_TOL   = 12'd48,
    parameter int          SQ_EDGES  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    output logic        send_resp,
    output logic        strt_cal,
    input  logic        cal_done,
    input  logic [11:0] error,
    input  logic        heading_rdy,
    input  logic        cntrIR,
    output logic [11:0] dsrd_hdng,
    output logic [9:0]  frwrd,
    output logic        moving,
    output logic        fanfare
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAL,
        S_TURN,
        S_RAMP,
        S_DECEL
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [3:0]  r_cmd_op;
    logic [3:0]  r_cmd_sq;
    logic [11:0] r_dsrd_hdng;
    logic [9:0]  r_frwrd;
    logic [4:0]  r_edge_cnt;
    logic        r_cntrIR_ff;
    logic        r_send_resp;
    logic        r_fanfare;

    logic        w_accept;
    logic        w_strt_cal;
    logic        w_load_move;
    logic        w_resp_set;
    logic        w_fanfare_set;
    logic        w_rise;
    logic [4:0]  w_edge_inc;
    logic [7:0]  w_target;
    logic        w_at_target;
    logic        w_past_target;
    logic [11:0] w_err_abs;
    logic        w_settled;
    logic [10:0] w_ramp_sum;
    logic [9:0]  w_ramp_up;
    logic [9:0]  w_decel_dn;

    // Target edge count is the line before the destination square.
    assign w_target      = 8'(int'(r_cmd_sq) * SQ_EDGES - 1);
    assign w_rise        = cntrIR & ~r_cntrIR_ff;
    assign w_edge_inc    = (w_rise && (r_edge_cnt != 5'd31)) ? r_edge_cnt + 5'd1 : r_edge_cnt;
    assign w_at_target   = ({3'b000, w_edge_inc} == w_target);
    assign w_past_target = ({3'b000, r_edge_cnt} >= w_target);

    // 12'h800 negates to itself and compares as large, so it never settles.
    assign w_err_abs  = error[11] ? (~error + 12'd1) : error;
    assign w_settled  = (w_err_abs < ERR_TOL);

    assign w_ramp_sum = {1'b0, r_frwrd} + {1'b0, FAST_INC};
    assign w_ramp_up  = (w_ramp_sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : w_ramp_sum[9:0];
    assign w_decel_dn = (r_frwrd > SLOW_DEC) ? r_frwrd - SLOW_DEC : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_strt_cal    = 1'b0;
        w_load_move   = 1'b0;
        w_resp_set    = 1'b0;
        w_fanfare_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_rdy && rst_n) begin
                    w_accept = 1'b1;
                    case (cmd[15:12])
                        4'd0: begin
                            w_strt_cal  = 1'b1;
                            w_state_nxt = S_CAL;
                        end
                        4'd2, 4'd3: begin
                            w_load_move = 1'b1;
                            w_state_nxt = S_TURN;
                        end
                        default: w_resp_set = 1'b1;
                    endcase
                end
            end
            S_CAL: begin
                if (cal_done) begin
                    w_resp_set  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_TURN: begin
                if (w_settled) begin
                    if (r_cmd_sq == 4'd0) begin
                        w_resp_set  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_fanfare_set = (r_cmd_op == 4'd3);
                        w_state_nxt   = S_RAMP;
                    end
                end
            end
            S_RAMP: begin
                if (w_rise && w_at_target) begin
                    w_state_nxt = S_DECEL;
                end
            end
            S_DECEL: begin
                if ((r_frwrd == 10'd0) && w_past_target) begin
                    w_resp_set  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_op    <= '0;
            r_cmd_sq    <= '0;
            r_dsrd_hdng <= '0;
            r_frwrd     <= '0;
            r_edge_cnt  <= '0;
            r_cntrIR_ff <= 1'b0;
            r_send_resp <= 1'b0;
            r_fanfare   <= 1'b0;
        end else begin
            r_cntrIR_ff <= cntrIR;
            r_send_resp <= w_resp_set;
            r_fanfare   <= w_fanfare_set;
            if (w_accept) begin
                r_cmd_op <= cmd[15:12];
                r_cmd_sq <= cmd[3:0];
            end
            if (w_load_move) begin
                r_dsrd_hdng <= (cmd[11:4] == 8'h00) ? 12'h000 : {cmd[11:4], 4'hF};
                r_edge_cnt  <= '0;
            end else if ((r_state == S_RAMP) || (r_state == S_DECEL)) begin
                r_edge_cnt <= w_edge_inc;
            end
            // Speed follows the state being left, even on a transition edge.
            case (r_state)
                S_RAMP:  if (heading_rdy) r_frwrd <= w_ramp_up;
                S_DECEL: if (heading_rdy) r_frwrd <= w_decel_dn;
                default: r_frwrd <= '0;
            endcase
        end
    end

    assign clr_cmd_rdy = w_accept;
    assign strt_cal    = w_strt_cal;
    assign send_resp   = r_send_resp;
    assign fanfare     = r_fanfare;
    assign dsrd_hdng   = r_dsrd_hdng;
    assign frwrd       = r_frwrd;
    assign moving      = (r_state == S_TURN) || (r_state == S_RAMP) || (r_state == S_DECEL);

endmodule

// File: tb/tb_move_cmd_exec.sv
// Self-checking bench for move_cmd_exec: randomized moves checked against a
// per-strobe speed/edge model derived from the command's squares count.
module tb_move_cmd_exec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic        strt_cal;
    logic        cal_done;
    logic [11:0] error;
    logic        heading_rdy;
    logic        cntrIR;
    logic [11:0] dsrd_hdng;
    logic [9:0]  frwrd;
    logic        moving;
    logic        fanfare;

    int n_checks = 0;
    int n_fail   = 0;

    move_cmd_exec #(
        .FAST_INC (10'd24),
        .SLOW_DEC (10'd48),
        .MAX_FRWRD(10'h2A0),
        .ERR_TOL  (12'd48),
        .SQ_EDGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .send_resp  (send_resp),
        .strt_cal   (strt_cal),
        .cal_done   (cal_done),
        .error      (error),
        .heading_rdy(heading_rdy),
        .cntrIR     (cntrIR),
        .dsrd_hdng  (dsrd_hdng),
        .frwrd      (frwrd),
        .moving     (moving),
        .fanfare    (fanfare)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [11:0] large_err();
        logic [11:0] tbl [5] = '{12'h200, 12'h800, 12'h030, 12'hFD0, 12'h7FF};
        return tbl[$urandom_range(0, 4)];
    endfunction

    function automatic logic [11:0] small_err();
        logic [11:0] tbl [5] = '{12'h000, 12'h010, 12'h02F, 12'hFD1, 12'hFFF};
        return tbl[$urandom_range(0, 4)];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; cmd = 16'h0000; cmd_rdy = 1'b1; cal_done = 1'b0;
        error = '0; heading_rdy = 1'b0; cntrIR = 1'b0;
        tick(); tick();
        n_checks++; if (clr_cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_clr: got %0b exp 0", clr_cmd_rdy); end
        n_checks++; if (strt_cal !== 1'b0) begin n_fail++; $display("FAIL rst_strt_cal: got %0b exp 0", strt_cal); end
        n_checks++; if (send_resp !== 1'b0) begin n_fail++; $display("FAIL rst_send_resp: got %0b exp 0", send_resp); end
        n_checks++; if (frwrd !== 10'd0) begin n_fail++; $display("FAIL rst_frwrd: got %0h exp 0", frwrd); end
        n_checks++; if (dsrd_hdng !== 12'd0) begin n_fail++; $display("FAIL rst_dsrd: got %0h exp 0", dsrd_hdng); end
        n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL rst_moving: got %0b exp 0", moving); end
        n_checks++; if (fanfare !== 1'b0) begin n_fail++; $display("FAIL rst_fanfare: got %0b exp 0", fanfare); end
        cmd_rdy = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_cal();
        cmd = 16'h0000; cmd_rdy = 1'b1;
        #1;
        n_checks++; if (clr_cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL cal_clr: got %0b exp 1", clr_cmd_rdy); end
        n_checks++; if (strt_cal !== 1'b1) begin n_fail++; $display("FAIL cal_strt: got %0b exp 1", strt_cal); end
        tick();
        cmd_rdy = 1'b0;
        #1;
        n_checks++; if (strt_cal !== 1'b0) begin n_fail++; $display("FAIL cal_strt_pulse: got %0b exp 0", strt_cal); end
        n_checks++; if (clr_cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL cal_clr_pulse: got %0b exp 0", clr_cmd_rdy); end
        for (int i = 0; i < 19; i++) begin
            tick();
            n_checks++; if (send_resp !== 1'b0) begin n_fail++; $display("FAIL cal_wait_resp: got %0b exp 0 at %0d", send_resp, i); end
        end
        cal_done = 1'b1;
        tick();
        cal_done = 1'b0;
        n_checks++; if (send_resp !== 1'b1) begin n_fail++; $display("FAIL cal_resp: got %0b exp 1", send_resp); end
        n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL cal_moving: got %0b exp 0", moving); end
        tick();
        n_checks++; if (send_resp !== 1'b0) begin n_fail++; $display("FAIL cal_resp_once: got %0b exp 0", send_resp); end
    endtask

    // Full move: accept, turn, ramp/decel with random strobes and IR edges.
    // With pend set, pc is held pending on cmd_rdy for the whole move.
    task automatic run_move(input logic [15:0] c, input bit pend, input logic [15:0] pc, input int hold);
        logic [3:0]  op       = c[15:12];
        logic [3:0]  sq       = c[3:0];
        logic [7:0]  hb       = c[11:4];
        logic [11:0] exp_hdng = (hb == 8'h00) ? 12'h000 : {hb, 4'hF};
        int          target   = int'(sq) * 2 - 1;
        int          f        = 0;
        int          edges    = 0;
        int          kr       = 0;
        int          guard    = 0;
        int          nlarge;
        bit          in_decel = 1'b0;
        bit          done     = 1'b0;
        logic        prev_ir  = 1'b0;
        logic        ir;
        logic        hr;

        cmd = c; cmd_rdy = 1'b1; heading_rdy = 1'b0; cntrIR = 1'b0; error = 12'h200;
        #1;
        n_checks++; if (clr_cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL mv_accept_clr %h: got %0b exp 1", c, clr_cmd_rdy); end
        n_checks++; if (strt_cal !== 1'b0) begin n_fail++; $display("FAIL mv_strt_cal %h: got %0b exp 0", c, strt_cal); end
        tick();
        cmd_rdy = pend;
        if (pend) cmd = pc;
        #1;
        n_checks++; if (moving !== 1'b1) begin n_fail++; $display("FAIL mv_turn_moving %h: got %0b exp 1", c, moving); end
        n_checks++; if (dsrd_hdng !== exp_hdng) begin n_fail++; $display("FAIL mv_dsrd %h: got %h exp %h", c, dsrd_hdng, exp_hdng); end
        n_checks++; if (clr_cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL mv_busy_clr %h: got %0b exp 0", c, clr_cmd_rdy); end

        nlarge = $urandom_range(0, 3);
        for (int i = 0; i < nlarge; i++) begin
            error = large_err();
            heading_rdy = 1'($urandom_range(0, 1));
            tick();
            n_checks++; if (frwrd !== 10'd0) begin n_fail++; $display("FAIL mv_turn_frwrd %h err %h: got %0h exp 0", c, error, frwrd); end
            n_checks++; if (moving !== 1'b1) begin n_fail++; $display("FAIL mv_turn_hold %h err %h: got %0b exp 1", c, error, moving); end
            n_checks++; if (send_resp !== 1'b0) begin n_fail++; $display("FAIL mv_turn_resp %h: got %0b exp 0", c, send_resp); end
        end
        error = small_err();
        heading_rdy = 1'($urandom_range(0, 1));
        tick();

        if (sq == 4'd0) begin
            n_checks++; if (send_resp !== 1'b1) begin n_fail++; $display("FAIL mv_zero_resp %h: got %0b exp 1", c, send_resp); end
            n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL mv_zero_moving %h: got %0b exp 0", c, moving); end
            n_checks++; if (frwrd !== 10'd0) begin n_fail++; $display("FAIL mv_zero_frwrd %h: got %0h exp 0", c, frwrd); end
            n_checks++; if (fanfare !== 1'b0) begin n_fail++; $display("FAIL mv_zero_fanfare %h: got %0b exp 0", c, fanfare); end
        end else begin
            n_checks++; if (fanfare !== (op == 4'd3)) begin n_fail++; $display("FAIL mv_fanfare %h: got %0b exp %0b", c, fanfare, op == 4'd3); end
            while (!done && guard < 600) begin
                n_checks++; if (frwrd !== 10'(f)) begin n_fail++; $display("FAIL mv_frwrd %h cyc %0d: got %0h exp %0h", c, guard, frwrd, f); end
                n_checks++; if (moving !== 1'b1) begin n_fail++; $display("FAIL mv_moving %h cyc %0d: got %0b exp 1", c, guard, moving); end
                n_checks++; if (send_resp !== 1'b0) begin n_fail++; $display("FAIL mv_early_resp %h cyc %0d: got %0b exp 0", c, guard, send_resp); end
                if (guard > 0) begin
                    n_checks++; if (fanfare !== 1'b0) begin n_fail++; $display("FAIL mv_fanfare_pulse %h: got %0b exp 0", c, fanfare); end
                end
                if (pend) begin
                    n_checks++; if (clr_cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL mv_pend_clr %h: got %0b exp 0", c, clr_cmd_rdy); end
                end
                if (in_decel && f == 0) begin
                    done = 1'b1;
                end else begin
                    hr = 1'($urandom_range(0, 1));
                    ir = prev_ir;
                    if ((kr >= hold || in_decel) && $urandom_range(0, 2) == 0) ir = ~prev_ir;
                    if (in_decel) begin
                        if (hr) f = (f > 48) ? f - 48 : 0;
                    end else begin
                        if (hr) begin
                            f = (f + 24 > 672) ? 672 : f + 24;
                            kr++;
                        end
                        if (ir && !prev_ir) begin
                            edges++;
                            if (edges == target) in_decel = 1'b1;
                        end
                    end
                    prev_ir = ir;
                    heading_rdy = hr; cntrIR = ir; error = 12'($urandom);
                    tick();
                    guard++;
                end
            end
            if (!done) begin
                n_checks++; n_fail++;
                $display("FAIL mv_timeout %h: got no completion within 600 cycles, exp completion", c);
            end
            heading_rdy = 1'b0;
            tick();
            n_checks++; if (send_resp !== 1'b1) begin n_fail++; $display("FAIL mv_resp %h: got %0b exp 1", c, send_resp); end
            n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL mv_done_moving %h: got %0b exp 0", c, moving); end
            n_checks++; if (dsrd_hdng !== exp_hdng) begin n_fail++; $display("FAIL mv_done_dsrd %h: got %h exp %h", c, dsrd_hdng, exp_hdng); end
        end

        heading_rdy = 1'b0;
        if (pend) begin
            n_checks++; if (clr_cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL mv_pend_ack %h: got %0b exp 1", pc, clr_cmd_rdy); end
            tick();
            n_checks++; if (send_resp !== 1'b1) begin n_fail++; $display("FAIL mv_pend_resp %h: got %0b exp 1", pc, send_resp); end
            cmd_rdy = 1'b0;
            #1;
            n_checks++; if (clr_cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL mv_pend_clr_drop %h: got %0b exp 0", pc, clr_cmd_rdy); end
        end
        tick();
        n_checks++; if (send_resp !== 1'b0) begin n_fail++; $display("FAIL mv_resp_once %h: got %0b exp 0", c, send_resp); end
    endtask

    task automatic test_move_spec();
        run_move(16'h2002, 1'b0, 16'h0000, 40);
        run_move(16'h33F1, 1'b0, 16'h0000, 10);
    endtask

    task automatic test_move_random();
        for (int i = 0; i < 10; i++) begin
            logic [3:0] op = ($urandom_range(0, 1) == 1) ? 4'd3 : 4'd2;
            logic [7:0] hb = 8'($urandom);
            logic [3:0] sq = 4'($urandom_range(0, 3));
            run_move({op, hb, sq}, 1'b0, 16'h0000, $urandom_range(0, 32));
        end
    endtask

    task automatic test_back_to_back();
        run_move(16'h2001, 1'b1, 16'hF000, 4);
        run_move(16'h3A22, 1'b1, 16'h1234, 0);
    endtask

    task automatic test_zero_and_other();
        run_move(16'h2BF0, 1'b0, 16'h0000, 0);
        cmd = 16'hF000; cmd_rdy = 1'b1;
        #1;
        n_checks++; if (clr_cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL other_clr: got %0b exp 1", clr_cmd_rdy); end
        n_checks++; if (strt_cal !== 1'b0) begin n_fail++; $display("FAIL other_strt: got %0b exp 0", strt_cal); end
        tick();
        cmd_rdy = 1'b0;
        n_checks++; if (send_resp !== 1'b1) begin n_fail++; $display("FAIL other_resp: got %0b exp 1", send_resp); end
        n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL other_moving: got %0b exp 0", moving); end
        n_checks++; if (dsrd_hdng !== 12'hBFF) begin n_fail++; $display("FAIL other_dsrd_hold: got %h exp bff", dsrd_hdng); end
        tick();
        n_checks++; if (send_resp !== 1'b0) begin n_fail++; $display("FAIL other_resp_once: got %0b exp 0", send_resp); end
    endtask

    task automatic test_reset_mid();
        cmd = 16'h2004; cmd_rdy = 1'b1; error = 12'h000; heading_rdy = 1'b0; cntrIR = 1'b0;
        #1;
        n_checks++; if (clr_cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL rm_accept: got %0b exp 1", clr_cmd_rdy); end
        tick();
        cmd_rdy = 1'b0;
        tick();
        heading_rdy = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++; if (frwrd !== 10'(24 * k)) begin n_fail++; $display("FAIL rm_ramp %0d: got %0h exp %0h", k, frwrd, 24 * k); end
        end
        heading_rdy = 1'b0;
        rst_n = 1'b0;
        cmd = 16'hF000; cmd_rdy = 1'b1;
        #1;
        n_checks++; if (frwrd !== 10'd0) begin n_fail++; $display("FAIL rm_frwrd: got %0h exp 0", frwrd); end
        n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL rm_moving: got %0b exp 0", moving); end
        n_checks++; if (dsrd_hdng !== 12'd0) begin n_fail++; $display("FAIL rm_dsrd: got %h exp 0", dsrd_hdng); end
        n_checks++; if (clr_cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL rm_clr: got %0b exp 0", clr_cmd_rdy); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (send_resp !== 1'b0) begin n_fail++; $display("FAIL rm_no_resp: got %0b exp 0", send_resp); end
        end
        cmd_rdy = 1'b0;
        rst_n = 1'b1;
        tick();
        n_checks++; if (send_resp !== 1'b0) begin n_fail++; $display("FAIL rm_post_resp: got %0b exp 0", send_resp); end
        cmd_rdy = 1'b1;
        #1;
        n_checks++; if (clr_cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL rm_next_clr: got %0b exp 1", clr_cmd_rdy); end
        tick();
        cmd_rdy = 1'b0;
        n_checks++; if (send_resp !== 1'b1) begin n_fail++; $display("FAIL rm_next_resp: got %0b exp 1", send_resp); end
        tick();
    endtask

    initial begin
        test_reset();
        test_cal();
        test_move_spec();
        test_move_random();
        test_back_to_back();
        test_zero_and_other();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
